// File: rtl/snn_pkg.sv
// Shared types and helpers for the spike front end, the trainer and the ODESA network.
package snn_pkg;

  localparam int CH_N = 100;

  typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

  typedef logic [CH_N:1] chan_vec_t;

  // Channel index (1-based) to one-hot vector; index 0 or out of range gives all zeros.
  function automatic chan_vec_t onehot(int unsigned idx);
    chan_vec_t v;
    v = '0;
    if (idx >= 1 && idx <= CH_N) v = chan_vec_t'(1) << (idx - 1);
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requester at or above ptr, else lowest overall.
module rr_arbiter #(
  parameter int p_s = 100
) (
  input  logic [p_s:1]                 req,
  input  logic [$clog2(p_s+1)-1:0]     ptr,
  output logic [p_s:1]                 grant,
  output logic [$clog2(p_s+1)-1:0]     idx,
  output logic                         valid
);

  localparam int IW = $clog2(p_s + 1);

  logic hit_hi;

  always_comb begin
    idx    = '0;
    hit_hi = 1'b0;
    grant  = '0;
    valid  = |req;
    // Scan downward so the final assignment is the lowest qualifying index.
    for (int k = p_s; k >= 1; k--) begin
      if (req[k] && (IW'(k) >= ptr)) begin
        idx    = IW'(k);
        hit_hi = 1'b1;
      end
    end
    if (!hit_hi) begin
      for (int k = p_s; k >= 1; k--) begin
        if (req[k]) idx = IW'(k);
      end
    end
    for (int k = 1; k <= p_s; k++) grant[k] = valid && (idx == IW'(k));
  end

endmodule

// File: rtl/spike_scheduler.sv
// Serialises multi-hot spike vectors into spaced one-hot events for the network input.
module spike_scheduler
  import snn_pkg::*;
#(
  parameter int p_s     = CH_N,
  parameter int p_gap   = 4,
  parameter int p_cnt_w = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [p_s:1]       i_event,
  input  logic               i_enable,
  input  logic               i_flush,
  output logic [p_s:1]       o_event,
  output logic               o_busy,
  output logic               o_drop,
  output logic [p_cnt_w-1:0] o_drop_cnt
);

  localparam int IW = $clog2(p_s + 1);
  localparam int GW = (p_gap > 0) ? $clog2(p_gap + 1) : 1;

  state_t          state, state_nxt;
  logic [p_s:1]    pending, pending_nxt, clear_mask;
  logic [IW-1:0]   ptr;
  logic [GW-1:0]   gap_cnt, gap_nxt;
  logic [p_s:1]    gnt;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_vld;
  logic            fire;
  logic            drop_nxt;

  rr_arbiter #(.p_s(p_s)) u_arb (
    .req   (pending),
    .ptr   (ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .valid (gnt_vld)
  );

  // The last GAP cycle doubles as the IDLE decision cycle, so exactly p_gap
  // zero cycles separate consecutive events.
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    fire      = 1'b0;
    case (state)
      IDLE: fire = i_enable && gnt_vld;
      EMIT: begin
        if (p_gap > 0) begin
          state_nxt = GAP;
          gap_nxt   = GW'(p_gap);
        end else begin
          state_nxt = IDLE;
          fire      = i_enable && gnt_vld;
        end
      end
      GAP: begin
        gap_nxt = gap_cnt - GW'(1);
        if (gap_cnt <= GW'(1)) begin
          state_nxt = IDLE;
          gap_nxt   = '0;
          fire      = i_enable && gnt_vld;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (fire) state_nxt = EMIT;
    if (i_flush) begin
      state_nxt = IDLE;
      gap_nxt   = '0;
      fire      = 1'b0;
    end
  end

  always_comb begin
    clear_mask  = fire ? gnt : '0;
    pending_nxt = i_flush ? '0 : ((pending & ~clear_mask) | i_event);
    drop_nxt    = !i_flush && (|(i_event & pending & ~clear_mask));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      pending    <= '0;
      ptr        <= IW'(1);
      gap_cnt    <= '0;
      o_event    <= '0;
      o_drop     <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      gap_cnt <= gap_nxt;
      o_event <= fire ? gnt : '0;
      o_drop  <= drop_nxt;
      if (fire) ptr <= (gnt_idx == IW'(p_s)) ? IW'(1) : gnt_idx + IW'(1);
      if (drop_nxt && !(&o_drop_cnt)) o_drop_cnt <= o_drop_cnt + p_cnt_w'(1);
    end
  end

  assign o_busy = (|pending) || (state != IDLE);

endmodule

// File: tb/tb_spike_scheduler.sv
// Directed bench for spike_scheduler: scoreboard of expected events plus spot checks.
module tb_spike_scheduler;
  import snn_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  chan_vec_t       ev, ev0, o_event, o_event0;
  logic            en, fl, en0, fl0;
  logic            o_busy, o_drop, o_busy0, o_drop0;
  logic [15:0]     o_drop_cnt, o_drop_cnt0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int drop_seen = 0;
  int c, d;

  typedef struct { chan_vec_t vec; int cyc; } exp_t;
  exp_t q[$];
  exp_t mon_e;

  spike_scheduler #(.p_s(CH_N), .p_gap(4), .p_cnt_w(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_event(ev), .i_enable(en), .i_flush(fl),
    .o_event(o_event), .o_busy(o_busy), .o_drop(o_drop), .o_drop_cnt(o_drop_cnt)
  );

  spike_scheduler #(.p_s(CH_N), .p_gap(0), .p_cnt_w(16)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_event(ev0), .i_enable(en0), .i_flush(fl0),
    .o_event(o_event0), .o_busy(o_busy0), .o_drop(o_drop0), .o_drop_cnt(o_drop_cnt0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) tick(1);
  endtask

  task automatic push(input int idx, input int at);
    exp_t e;
    e.vec = onehot(idx);
    e.cyc = at;
    q.push_back(e);
  endtask

  // Scoreboard side: every nonzero o_event, or every due entry, is matched in order.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_drop) drop_seen++;
      if (o_event !== '0 || (q.size() > 0 && q[0].cyc <= cyc)) begin
        if (q.size() == 0) chk("unexpected_event", o_event, 128'd0);
        else begin
          mon_e = q.pop_front();
          chk("event_cycle", cyc, mon_e.cyc);
          chk("event_vec", o_event, mon_e.vec);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; ev = '0; en = 1'b1; fl = 1'b0; ev0 = '0; en0 = 1'b1; fl0 = 1'b0;
    tick(3);
    chk("rst_event", o_event, 128'd0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_drop", o_drop, 1'b0);
    chk("rst_drop_cnt", o_drop_cnt, 16'd0);
    rst = 1'b0;
    tick(2);

    // single spike: event two cycles later, busy through the 4-cycle gap
    c = cyc; ev = onehot(7); push(7, c + 2); tick(); ev = '0;
    wait_to(c + 6); chk("busy_last_gap", o_busy, 1'b1);
    wait_to(c + 7); chk("busy_idle", o_busy, 1'b0);
    chk("no_drop_single", drop_seen, 0);

    // fresh pointer, coincident spikes spread 5 cycles apart
    rst = 1'b1; tick(); rst = 1'b0; tick();
    c = cyc; ev = onehot(3) | onehot(50) | onehot(99);
    push(3, c + 2); push(50, c + 7); push(99, c + 12);
    tick(); ev = '0;
    wait_to(c + 17); chk("busy_after_three", o_busy, 1'b0);

    // pointer sits at 100: 100 goes before 2
    c = cyc; ev = onehot(2) | onehot(100); push(100, c + 2); push(2, c + 7);
    tick(); ev = '0;
    wait_to(c + 12);
    chk("no_drop_yet", drop_seen, 0);

    // re-trigger while disabled
    en = 1'b0;
    c = cyc; ev = onehot(5); tick(); ev = onehot(5); tick(); ev = '0;
    chk("drop_pulse", o_drop, 1'b1);
    chk("drop_cnt_1", o_drop_cnt, 16'd1);
    tick();
    chk("drop_one_cycle", o_drop, 1'b0);
    chk("busy_disabled", o_busy, 1'b1);
    en = 1'b1; d = cyc; push(5, d + 1);
    wait_to(d + 6); chk("busy_after_drop", o_busy, 1'b0);

    // two merged bits in one cycle count once
    en = 1'b0;
    ev = onehot(8) | onehot(9); tick(); tick(); ev = '0;
    chk("multi_drop_pulse", o_drop, 1'b1);
    chk("multi_drop_cnt", o_drop_cnt, 16'd2);

    // flush mid-gap with 10 pending and arrivals in the flush cycle
    ev = '0;
    for (int k = 30; k <= 37; k++) ev = ev | onehot(k);
    tick(); ev = '0;
    en = 1'b1; d = cyc; push(8, d + 1);
    wait_to(d + 3);
    ev = onehot(20) | onehot(9); fl = 1'b1;
    tick(); ev = '0; fl = 1'b0;
    chk("flush_busy", o_busy, 1'b0);
    chk("flush_event", o_event, 128'd0);
    chk("flush_no_drop", o_drop, 1'b0);
    chk("flush_cnt_kept", o_drop_cnt, 16'd2);
    wait_to(d + 16);

    // pointer retained across flush (last grant 8): 12 before 5
    c = cyc; ev = onehot(5) | onehot(12); push(12, c + 2); push(5, c + 7);
    tick(); ev = '0;
    wait_to(c + 12); chk("busy_final", o_busy, 1'b0);
    chk("queue_drained", q.size(), 0);

    // zero gap: back-to-back, then async reset during the second event
    c = cyc; ev0 = onehot(1) | onehot(2); tick(); ev0 = '0;
    wait_to(c + 2); chk("gap0_first", o_event0, onehot(1));
    tick();         chk("gap0_second", o_event0, onehot(2));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_event", o_event0, 128'd0);
    chk("async_rst_busy", o_busy0, 1'b0);
    chk("async_rst_cnt0", o_drop_cnt0, 16'd0);
    chk("async_rst_cnt", o_drop_cnt, 16'd0);
    tick(); rst = 1'b0; tick(2);
    chk("post_rst_event0", o_event0, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
